// File: rtl/mem_req_responder.sv
// mem_req_responder: arbitrates instruction-fetch and data requests onto a
// single-port variable-latency RAM. Data requests have strict priority over
// fetches. The RAM-side address, store data and strobes come only from
// registers latched on entry to an access, so they stay stable while the
// CPU-side inputs change. An access that sees no ramready within TIMEOUT
// cycles is forced to complete, returns ERR_WORD on reads and sets the
// sticky err flag, which only reset clears.
module mem_req_responder #(
  parameter int          TIMEOUT  = 64,
  parameter logic [31:0] ERR_WORD = 32'hBAD1BAD1
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        iREN,
  input  logic [31:0] iaddr,
  input  logic        dREN,
  input  logic        dWEN,
  input  logic [31:0] daddr,
  input  logic [31:0] dstore,
  output logic [31:0] iload,
  output logic [31:0] dload,
  output logic        iwait,
  output logic        dwait,
  output logic        ramREN,
  output logic        ramWEN,
  output logic [31:0] ramaddr,
  output logic [31:0] ramstore,
  input  logic [31:0] ramload,
  input  logic        ramready,
  output logic        err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DACC = 2'd1,
    IACC = 2'd2,
    RESP = 2'd3
  } state_t;

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  state_t      state_q;
  logic [7:0]  cnt_q;
  logic        opWrite_q;
  logic        srcData_q;
  logic [31:0] addr_q;
  logic [31:0] store_q;
  logic [31:0] iload_q;
  logic [31:0] dload_q;
  logic        err_q;

  logic inAccess;

  // Arbitration, access sequencing, timeout and load capture in one register block.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q   <= IDLE;
      cnt_q     <= 8'd0;
      opWrite_q <= 1'b0;
      srcData_q <= 1'b0;
      addr_q    <= 32'd0;
      store_q   <= 32'd0;
      iload_q   <= 32'd0;
      dload_q   <= 32'd0;
      err_q     <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          cnt_q <= 8'd0;
          if (dREN || dWEN) begin
            state_q   <= DACC;
            srcData_q <= 1'b1;
            opWrite_q <= dWEN;
            addr_q    <= daddr;
            store_q   <= dstore;
          end else if (iREN) begin
            state_q   <= IACC;
            srcData_q <= 1'b0;
            opWrite_q <= 1'b0;
            addr_q    <= iaddr;
          end
        end
        DACC, IACC: begin
          if (ramready) begin
            state_q <= RESP;
            if (!opWrite_q) begin
              if (srcData_q) dload_q <= ramload;
              else           iload_q <= ramload;
            end
          end else if (cnt_q == CNT_LAST) begin
            state_q <= RESP;
            err_q   <= 1'b1;
            if (!opWrite_q) begin
              if (srcData_q) dload_q <= ERR_WORD;
              else           iload_q <= ERR_WORD;
            end
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        RESP: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  // RAM strobes decoded from the registered state so reset drops them immediately.
  always_comb begin
    inAccess = (state_q == DACC) || (state_q == IACC);
    ramREN   = inAccess && !opWrite_q;
    ramWEN   = inAccess && opWrite_q;
    ramaddr  = addr_q;
    ramstore = store_q;
  end

  // Wait handshakes fall for exactly the RESP cycle of the matching source.
  always_comb begin
    dwait = (dREN || dWEN) && !((state_q == RESP) && srcData_q);
    iwait = iREN && !((state_q == RESP) && !srcData_q);
  end

  assign iload = iload_q;
  assign dload = dload_q;
  assign err   = err_q;

endmodule

// File: doc/mem_req_responder.md
Name: mem_req_responder

Overview:
- Memory-side responder for the datapath's instruction-fetch (iREN) and data-access (dREN/dWEN) request strobes.
- Arbitrates the two request streams onto one single-port RAM with variable latency.
- Holds RAM address, data and strobes stable for the whole access.
- Returns load data with iwait/dwait handshakes, and flags RAM accesses that time out.

Parameters:
- TIMEOUT, 64, max cycles in an access state without ramready before forced completion (range 2..255).
- ERR_WORD, 32'hBAD1BAD1, load value returned on a timed-out read.

Ports:
- CLK  in  1  clock, rising edge.
- nRST  in  1  asynchronous, active-low reset.
- iREN  in  1  instruction fetch request, held until iwait low.
- iaddr  in  32  fetch word address.
- dREN  in  1  data read request, held until dwait low.
- dWEN  in  1  data write request, held until dwait low.
- daddr  in  32  data address.
- dstore  in  32  write data.
- iload  out  32  fetched instruction, valid while iwait=0 and iREN=1.
- dload  out  32  read data, valid while dwait=0 and dREN=1.
- iwait  out  1  high while fetch pending.
- dwait  out  1  high while data access pending.
- ramREN  out  1  RAM read strobe.
- ramWEN  out  1  RAM write strobe.
- ramaddr  out  32  RAM address.
- ramstore  out  32  RAM write data.
- ramload  in  32  RAM read data, sampled when ramready=1.
- ramready  in  1  one-cycle RAM completion pulse.
- err  out  1  sticky timeout flag.

Behaviour:
- Reset (async, nRST=0):
  - State=IDLE; counter=0.
  - ramREN=ramWEN=0, ramaddr=0, ramstore=0, iload=0, dload=0, err=0.
  - Strobes drop immediately, including mid-access; the in-flight access is abandoned.
- States and transitions:
  - IDLE: if dREN|dWEN, go to DACC; else if iREN, go to IACC; else stay. Data has strict priority over instruction.
  - DACC/IACC: on entry, latch op, address and store data into registers. Drive ramREN/ramWEN/ramaddr/ramstore from those registers only, so they stay stable even if CPU inputs change.
  - In DACC/IACC, counter increments each cycle. On ramready=1, go to RESP with source=op. On counter==TIMEOUT-1 without ramready, go to RESP and set err=1.
  - RESP: strobes 0. Next state IDLE.
- Load capture:
  - Read completion: ramload is registered into dload (DACC) or iload (IACC) on the ramready edge.
  - Read timeout: ERR_WORD is loaded instead.
  - Writes: dload unchanged.
- Wait outputs (combinational):
  - dwait = (dREN|dWEN) & !(state==RESP & source==D).
  - iwait = iREN & !(state==RESP & source==I).
  - So a wait is high in IDLE whenever the request is up, and low exactly one cycle (RESP).
- Latency: request visible in IDLE at cycle 0; RAM strobe at cycle 1; ramready earliest at cycle 1; wait low at cycle 2. Minimum 3 cycles per access including the IDLE return.
- dREN and dWEN both high: write performed (ramWEN=1, ramREN=0); dREN ignored for that access.
- Request withdrawn mid-access: the RAM access still completes. RESP still occurs and the load register updates, but no wait output drops for the withdrawn request.
- Simultaneous i and d requests: data served first. Fetch served on the next IDLE→IACC, unless a new data request is pending then (data starvation of fetch is permitted).
- ramready outside DACC/IACC is ignored.
- ramREN and ramWEN are never both 1.
- err clears only on reset.
- Counter: 8 bits, reset to 0 on each entry to DACC/IACC; no wrap within an access.

Test Plan:
- Reset mid-access: assert nRST=0 during DACC write → ramWEN=0 asynchronously (same cycle), state IDLE, dload=0, err=0.
- Single fetch: iREN=1, iaddr=0x40, RAM returns 0x3C010001 with ramready on first access cycle → ramREN=1, ramaddr=0x40 in cycle 1; iwait=0, iload=0x3C010001 in cycle 2.
- Contention: iREN=1 and dREN=1 (daddr=0x100) in the same cycle → first access ramaddr=0x100 and dwait drops first; then fetch issued, iwait drops 3 cycles later with RAM latency 1.
- Write, variable latency: dWEN=1, daddr=0x200, dstore=0xDEADBEEF, ramready after 5 cycles; change daddr mid-access → ramaddr stays 0x200 and ramstore stays 0xDEADBEEF throughout; dwait low exactly one cycle; dload unchanged.
- Timeout: dREN=1, ramready never asserted, TIMEOUT=64 → after 64 access cycles, dload=0xBAD1BAD1, dwait low one cycle, err=1 and remains 1 on later good accesses.
- Both dREN=1 and dWEN=1: ramWEN=1, ramREN=0; dload not modified.
